// File: rtl/if_fetch_unit_if.sv
// Fetch-side bus bundle: IM lookup, redirect input, decode valid/ready handshake and perf count.
interface if_fetch_unit_if;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] fetch_cnt;

  modport master (
    output im_addr,
    input  im_instr,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc,
    output if_pc4,
    output fetch_cnt
  );

  modport slave (
    input  im_addr,
    output im_instr,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc,
    input  if_pc4,
    input  fetch_cnt
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch unit: owns the PC, reads the combinational IM, queues {pc, instr} for decode.
// Define IF_PERF_CNT_EN to enable the fetch_cnt performance counter (tied to 0 otherwise).
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic           clk,
  input  logic           reset,
  if_fetch_unit_if.master bus
);
  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]      r_pc;
  logic [31:0]      r_buf_pc    [BUF_DEPTH];
  logic [31:0]      r_buf_instr [BUF_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_fetch;
  logic w_unused_redirect_lsb;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CNT_W'(BUF_DEPTH));
  assign w_pop   = w_valid & bus.if_ready;
  // A pop frees the slot this cycle, so a full buffer can still accept the new fetch.
  assign w_fetch = !bus.redirect_valid & (!w_full | w_pop);

  assign w_unused_redirect_lsb = ^bus.redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= {RESET_PC[31:2], 2'b00};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.redirect_valid) begin
      r_pc     <= {bus.redirect_pc[31:2], 2'b00};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_fetch) begin
        r_pc     <= r_pc + 32'd4;
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_fetch, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: every read is gated by a non-zero count.
  always_ff @(posedge clk) begin
    if (!reset && w_fetch) begin
      r_buf_pc[r_wr_ptr]    <= r_pc;
      r_buf_instr[r_wr_ptr] <= bus.im_instr;
    end
  end

  assign bus.im_addr  = r_pc;
  assign bus.if_valid = w_valid;
  assign bus.if_instr = w_valid ? r_buf_instr[r_rd_ptr] : '0;
  assign bus.if_pc    = w_valid ? r_buf_pc[r_rd_ptr] : '0;
  assign bus.if_pc4   = w_valid ? (r_buf_pc[r_rd_ptr] + 32'd4) : '0;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_cnt <= '0;
    end else if (w_fetch) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign bus.fetch_cnt = r_fetch_cnt;
`else
  assign bus.fetch_cnt = '0;
`endif

endmodule
